// File: rtl/mul32_pkg.sv
// rtl/mul32_pkg.sv - shared types and constants for the sequential 32x32 multiplier
package mul32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int MUL_W    = 32;
  localparam int MUL_ITER = 32;
  localparam int CNT_W    = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

endpackage

// File: rtl/neg64.sv
// rtl/neg64.sv - combinational 64-bit two's-complement negate with enable
module neg64 (
  input  logic        en,
  input  logic [63:0] in,
  output logic [63:0] out
);

  assign out = en ? (~in + 64'd1) : in;

endmodule

// File: rtl/mul32s_seq.sv
// rtl/mul32s_seq.sv - sequential signed/unsigned 32x32 -> 64 shift-add multiplier
module mul32s_seq
  import mul32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  mul_state_t           state, state_nx;
  logic                 neg;
  logic [MUL_W-1:0]     mag_a, mag_b;
  logic [2*MUL_W-1:0]   acc;
  logic [2*MUL_W-1:0]   acc_fix;
  logic [CNT_W-1:0]     cnt;
  logic [2*MUL_W-1:0]   prod_q;
  logic                 out_valid_q;

  logic                 accept;
  logic                 neg_a, neg_b;
  logic [MUL_W-1:0]     mag_a_d, mag_b_d;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;

  // Magnitudes are 32-bit unsigned, so -2^31 maps to 0x8000_0000 without overflow.
  assign neg_a   = is_signed & mcand[MUL_W-1];
  assign neg_b   = is_signed & mplier[MUL_W-1];
  assign mag_a_d = neg_a ? (~mcand + 32'd1) : mcand;
  assign mag_b_d = neg_b ? (~mplier + 32'd1) : mplier;

  neg64 u_neg64 (
    .en  (neg),
    .in  (acc),
    .out (acc_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == CNT_LAST) state_nx = SIGN;
      SIGN:    state_nx = DONE;
      DONE:    if (out_valid_q && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg         <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // out_valid is registered, so it rises one cycle after prod settles in SIGN.
      out_valid_q <= (state == DONE) && !(out_valid_q && out_ready);
      case (state)
        IDLE: begin
          if (accept) begin
            neg   <= neg_a ^ neg_b;
            mag_a <= mag_a_d;
            mag_b <= mag_b_d;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (mag_b[0]) begin
            acc <= acc + ({{MUL_W{1'b0}}, mag_a} << cnt);
          end
          mag_b <= mag_b >> 1;
          cnt   <= cnt + 1'b1;
        end
        SIGN: begin
          prod_q <= acc_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
